// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the CPU MEM-stage bus: word RAM plus MMIO (TX FIFO, STATUS, CYCLES).
// Optional cycle counter enabled by defining DMEM_CYCLE_COUNTER_EN.
module mips_dmem_responder #(
    parameter int unsigned RAM_SIZE   = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned AW = $clog2(RAM_SIZE);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CYCLES = 2'd2;

    logic [31:0]   ram [RAM_SIZE];
    logic [31:0]   fifoMem [FIFO_DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [31:0]   cyclesValue;
    logic [31:0]   readNext;

    logic          isMmio;
    logic [1:0]    regSel;
    logic [AW-1:0] wordIdx;
    logic          txWrite;
    logic          statusWrite;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          unusedAddr;

    assign isMmio      = addr[31];
    assign regSel      = addr[3:2];
    assign wordIdx     = addr[AW+1:2];
    assign unusedAddr  = ^{addr[30:AW+2], addr[1:0]};

    assign txWrite     = memwrite && isMmio && (regSel == REG_TXDATA);
    assign statusWrite = memwrite && isMmio && (regSel == REG_STATUS);
    assign full        = (count == CW'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign pop         = tx_valid && tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push        = txWrite && (!full || pop);

    assign tx_valid    = !empty;
    assign tx_data     = fifoMem[rdPtr];

    // RAM storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (memwrite && !isMmio) begin
            ram[wordIdx] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr] <= writedata;
        end
    end

    // Read mux samples pre-edge state, so same-edge writes are not visible.
    always_comb begin
        readNext = '0;
        if (!isMmio) begin
            readNext = ram[wordIdx];
        end else begin
            case (regSel)
                REG_STATUS: readNext = {28'b0, overflow, full, empty, 1'b0};
                REG_CYCLES: readNext = cyclesValue;
                default:    readNext = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= readNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A dropping push outranks a STATUS clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (txWrite && full && !pop) begin
            overflow <= 1'b1;
        end else if (statusWrite) begin
            overflow <= 1'b0;
        end
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycles;
    logic        cyclesWrite;

    assign cyclesWrite = memwrite && isMmio && (regSel == REG_CYCLES);
    assign cyclesValue = cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles <= '0;
        end else if (cyclesWrite) begin
            cycles <= writedata;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end
`else
    assign cyclesValue = '0;
`endif

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed self-checking bench for mips_dmem_responder (RAM, TX FIFO, STATUS, CYCLES, async reset).
module tb_mips_dmem_responder;

    localparam logic [31:0] TXDATA_ADDR = 32'h8000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h8000_0004;
    localparam logic [31:0] CYCLES_ADDR = 32'h8000_0008;
    localparam logic [31:0] RSVD_ADDR   = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int passCount = 0;
    int checkCount = 0;

    mips_dmem_responder #(.RAM_SIZE(64), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic busCycle(input logic we, input logic [31:0] a, input logic [31:0] d);
        memwrite  = we;
        addr      = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
        addr      = 32'h0;
        writedata = 32'h0;
    endtask

    task automatic drain(input string tag, input logic [31:0] first, input int n);
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, 32'(tx_valid), 32'd1);
            check({tag, "_data"}, tx_data, first + 32'(i));
            tick();
        end
        tx_ready = 1'b0;
        check({tag, "_empty"}, 32'(tx_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        memwrite  = 1'b0;
        addr      = 32'h0;
        writedata = 32'h0;
        tx_ready  = 1'b0;
        #1;
        check("rst_readdata", readdata, 32'h0);
        check("rst_txvalid", 32'(tx_valid), 32'd0);
        #11;
        reset = 1'b0;
        tick();

        // RAM write, read, alias, read-before-write
        busCycle(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        busCycle(1'b0, 32'h0000_0010, 32'h0);
        check("ram_read", readdata, 32'hDEAD_BEEF);
        busCycle(1'b0, 32'h0000_0110, 32'h0);
        check("ram_alias", readdata, 32'hDEAD_BEEF);
        busCycle(1'b1, 32'h0000_0010, 32'h1234_5678);
        check("ram_rbw_old", readdata, 32'hDEAD_BEEF);
        busCycle(1'b0, 32'h0000_0010, 32'h0);
        check("ram_rbw_new", readdata, 32'h1234_5678);
        busCycle(1'b0, STATUS_ADDR, 32'h0);
        check("status_idle", readdata, 32'h2);

        // Fill with no drain, then overflow
        for (int i = 1; i <= 4; i++) busCycle(1'b1, TXDATA_ADDR, 32'(i));
        busCycle(1'b0, STATUS_ADDR, 32'h0);
        check("fill_status", readdata, 32'h4);
        busCycle(1'b1, TXDATA_ADDR, 32'd5);
        busCycle(1'b0, STATUS_ADDR, 32'h0);
        check("ovf_status", readdata, 32'hC);
        busCycle(1'b0, TXDATA_ADDR, 32'h0);
        check("txdata_read", readdata, 32'h0);
        busCycle(1'b0, RSVD_ADDR, 32'h0);
        check("rsvd_read", readdata, 32'h0);
        drain("drain1", 32'd1, 4);
        busCycle(1'b0, STATUS_ADDR, 32'h0);
        check("drained_status", readdata, 32'hA);
        busCycle(1'b1, STATUS_ADDR, 32'hFFFF_FFFF);
        busCycle(1'b0, STATUS_ADDR, 32'h0);
        check("ovf_cleared", readdata, 32'h2);

        // Full with simultaneous pop: 6,7,8 then 9 survive
        for (int i = 5; i <= 8; i++) busCycle(1'b1, TXDATA_ADDR, 32'(i));
        tx_ready = 1'b1;
        busCycle(1'b1, TXDATA_ADDR, 32'd9);
        tx_ready = 1'b0;
        busCycle(1'b0, STATUS_ADDR, 32'h0);
        check("full_pop_status", readdata, 32'h4);
        drain("drain2", 32'd6, 4);

        // Overflow then STATUS write: set is visible, later clear works
        for (int i = 1; i <= 4; i++) busCycle(1'b1, TXDATA_ADDR, 32'(i));
        busCycle(1'b1, TXDATA_ADDR, 32'd99);
        busCycle(1'b1, STATUS_ADDR, 32'h0);
        check("race_ovf_set", readdata, 32'hC);
        busCycle(1'b0, STATUS_ADDR, 32'h0);
        check("race_ovf_clear", readdata, 32'h4);
        drain("drain3", 32'd1, 4);

        // Cycle counter load and wrap
        busCycle(1'b1, CYCLES_ADDR, 32'hFFFF_FFFE);
        busCycle(1'b0, 32'h0, 32'h0);
`ifdef DMEM_CYCLE_COUNTER_EN
        busCycle(1'b0, CYCLES_ADDR, 32'h0);
        check("cyc0", readdata, 32'hFFFF_FFFF);
        busCycle(1'b0, CYCLES_ADDR, 32'h0);
        check("cyc1", readdata, 32'h0000_0000);
        busCycle(1'b0, CYCLES_ADDR, 32'h0);
        check("cyc2", readdata, 32'h0000_0001);
`else
        busCycle(1'b0, CYCLES_ADDR, 32'h0);
        check("cyc0", readdata, 32'h0);
        busCycle(1'b0, CYCLES_ADDR, 32'h0);
        check("cyc1", readdata, 32'h0);
`endif

        // Async reset mid-operation with 3 queued words
        for (int i = 1; i <= 3; i++) busCycle(1'b1, TXDATA_ADDR, 32'(i));
        busCycle(1'b0, 32'h0000_0010, 32'h0);
        check("pre_rst_valid", 32'(tx_valid), 32'd1);
        check("pre_rst_read", readdata, 32'h1234_5678);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(tx_valid), 32'd0);
        check("async_rst_read", readdata, 32'h0);
        #1;
        reset = 1'b0;
        busCycle(1'b0, STATUS_ADDR, 32'h0);
        check("post_rst_status", readdata, 32'h2);
        busCycle(1'b0, 32'h0000_0010, 32'h0);
        check("ram_kept", readdata, 32'h1234_5678);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
